jtag_tap_registers: RTL and testbench



---
 rtl/jtag_tap_registers.sv | 142 ++++++++++++++
 tb/tb_jtag_tap_registers.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_registers.sv
`default_nettype none
// ============================================================================
// Module  : jtag_tap_registers
// Purpose : JTAG IR, IDCODE, BYPASS and user DR chains driven by TAP state.
//           Optional macro JTAG_TAP_IR_STATUS_EN adds a CaptureIR status port.
// Revision: 1.0
// ============================================================================
module jtag_tap_registers #(
    parameter int                     IR_WIDTH      = 5,
    parameter int                     USER_DR_WIDTH = 32,
    parameter logic [31:0]            IDCODE_VALUE  = 32'h00000001,
    parameter logic [IR_WIDTH-1:0]    IDCODE_INST   = 5'h01,
    parameter logic [IR_WIDTH-1:0]    USER_INST     = 5'h11
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [3:0]                io_currState,
    input  logic                      io_tdi,
`ifdef JTAG_TAP_IR_STATUS_EN
    input  logic [IR_WIDTH-3:0]       io_ir_capture_status,
`endif
    output logic                      io_tdo,
    output logic                      io_tdo_en,
    output logic [IR_WIDTH-1:0]       io_instruction,
    input  logic [USER_DR_WIDTH-1:0]  io_user_capture_data,
    output logic                      io_user_update_valid,
    output logic [USER_DR_WIDTH-1:0]  io_user_update_data
);

    localparam logic [3:0] c_test_logic_reset = 4'hF;
    localparam logic [3:0] c_capture_dr       = 4'h6;
    localparam logic [3:0] c_shift_dr         = 4'h2;
    localparam logic [3:0] c_update_dr        = 4'h5;
    localparam logic [3:0] c_capture_ir       = 4'hE;
    localparam logic [3:0] c_shift_ir         = 4'hA;
    localparam logic [3:0] c_update_ir        = 4'hD;

    logic [IR_WIDTH-1:0]      r_ir_chain;
    logic [IR_WIDTH-1:0]      r_instruction;
    logic [31:0]              r_idcode_chain;
    logic [USER_DR_WIDTH-1:0] r_user_chain;
    logic                     r_bypass;
    logic                     r_update_valid;
    logic [USER_DR_WIDTH-1:0] r_update_data;

    logic                     w_sel_idcode;
    logic                     w_sel_user;
    logic [IR_WIDTH-1:0]      w_ir_capture;
    logic [USER_DR_WIDTH-1:0] w_user_shifted;
    logic                     w_tdo;
    logic                     w_tdo_en;

    // DR selection follows the active instruction, never the IR shift chain
    assign w_sel_idcode = (r_instruction == IDCODE_INST);
    assign w_sel_user   = (r_instruction == USER_INST);

`ifdef JTAG_TAP_IR_STATUS_EN
    assign w_ir_capture = {io_ir_capture_status, 2'b01};
`else
    assign w_ir_capture = IR_WIDTH'(2'b01);
`endif

    generate
        if (USER_DR_WIDTH > 1) begin : g_user_wide
            assign w_user_shifted = {io_tdi, r_user_chain[USER_DR_WIDTH-1:1]};
        end else begin : g_user_one
            assign w_user_shifted = io_tdi;
        end
    endgenerate

    always_comb begin
        w_tdo    = 1'b0;
        w_tdo_en = 1'b0;
        case (io_currState)
            c_shift_ir: begin
                w_tdo_en = 1'b1;
                w_tdo    = r_ir_chain[0];
            end
            c_shift_dr: begin
                w_tdo_en = 1'b1;
                if (w_sel_idcode)
                    w_tdo = r_idcode_chain[0];
                else if (w_sel_user)
                    w_tdo = r_user_chain[0];
                else
                    w_tdo = r_bypass;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ir_chain     <= '0;
            r_instruction  <= IDCODE_INST;
            r_idcode_chain <= '0;
            r_user_chain   <= '0;
            r_bypass       <= 1'b0;
            r_update_valid <= 1'b0;
            r_update_data  <= '0;
        end else begin
            r_update_valid <= 1'b0;
            case (io_currState)
                c_test_logic_reset: r_instruction <= IDCODE_INST;
                c_capture_ir:       r_ir_chain    <= w_ir_capture;
                c_shift_ir:         r_ir_chain    <= {io_tdi, r_ir_chain[IR_WIDTH-1:1]};
                c_update_ir:        r_instruction <= r_ir_chain;
                c_capture_dr: begin
                    if (w_sel_idcode)
                        r_idcode_chain <= IDCODE_VALUE;
                    else if (w_sel_user)
                        r_user_chain <= io_user_capture_data;
                    else
                        r_bypass <= 1'b0;
                end
                c_shift_dr: begin
                    if (w_sel_idcode)
                        r_idcode_chain <= {io_tdi, r_idcode_chain[31:1]};
                    else if (w_sel_user)
                        r_user_chain <= w_user_shifted;
                    else
                        r_bypass <= io_tdi;
                end
                c_update_dr: begin
                    if (w_sel_user) begin
                        r_update_valid <= 1'b1;
                        r_update_data  <= r_user_chain;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_tdo               = w_tdo;
    assign io_tdo_en            = w_tdo_en;
    assign io_instruction       = r_instruction;
    assign io_user_update_valid = r_update_valid;
    assign io_user_update_data  = r_update_data;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_registers.sv
`default_nettype none
// ============================================================================
// Module  : tb_jtag_tap_registers
// Purpose : Self-checking bench for jtag_tap_registers (vector table + model).
// Revision: 1.0
// ============================================================================
module tb_jtag_tap_registers;

    localparam logic [31:0] IDV  = 32'h00000001;
    localparam logic [4:0]  IDC  = 5'h01;
    localparam logic [4:0]  USR  = 5'h11;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  curr_state;
    logic        tdi;
    logic        tdo;
    logic        tdo_en;
    logic [4:0]  instruction;
    logic [31:0] cap_data;
    logic        upd_valid;
    logic [31:0] upd_data;
    logic [2:0]  ir_status = 3'b101;

    always #5 clock = ~clock;

    jtag_tap_registers dut (
        .clock                (clock),
        .reset                (reset),
        .io_currState         (curr_state),
        .io_tdi               (tdi),
`ifdef JTAG_TAP_IR_STATUS_EN
        .io_ir_capture_status (ir_status),
`endif
        .io_tdo               (tdo),
        .io_tdo_en            (tdo_en),
        .io_instruction       (instruction),
        .io_user_capture_data (cap_data),
        .io_user_update_valid (upd_valid),
        .io_user_update_data  (upd_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: chains kept as plain numbers, updated from the state rules
    logic [4:0]  m_ir, m_instr;
    logic [31:0] m_id, m_user, m_data;
    logic        m_byp, m_valid;

    function automatic logic [4:0] ir_capture_value();
`ifdef JTAG_TAP_IR_STATUS_EN
        return (5'(ir_status) << 2) + 5'd1;
`else
        return 5'd1;
`endif
    endfunction

    function automatic logic model_tdo(input logic [3:0] s);
        if (s == 4'hA) return m_ir[0];
        if (s == 4'h2) begin
            if (m_instr == IDC) return m_id[0];
            if (m_instr == USR) return m_user[0];
            return m_byp;
        end
        return 1'b0;
    endfunction

    task automatic model_step(input logic r, input logic [3:0] s, input logic t,
                              input logic [31:0] cap);
        if (!r) begin
            m_instr = IDC; m_ir = 0; m_id = 0; m_user = 0; m_byp = 0;
            m_valid = 0; m_data = 0;
        end else begin
            m_valid = 0;
            case (s)
                4'hF: m_instr = IDC;
                4'hE: m_ir = ir_capture_value();
                4'hA: m_ir = (m_ir >> 1) + (5'(t) * 5'd16);
                4'hD: m_instr = m_ir;
                4'h6: if (m_instr == IDC) m_id = IDV;
                      else if (m_instr == USR) m_user = cap;
                      else m_byp = 0;
                4'h2: if (m_instr == IDC) m_id = (m_id >> 1) + (32'(t) << 31);
                      else if (m_instr == USR) m_user = (m_user >> 1) + (32'(t) << 31);
                      else m_byp = t;
                4'h5: if (m_instr == USR) begin m_valid = 1; m_data = m_user; end
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // One TCK cycle: drive, check combinational outputs, clock, check registered outputs
    task automatic apply(input logic r, input logic [3:0] s, input logic t,
                         input logic [31:0] cap, output logic o_tdo, output logic o_en);
        reset = r; curr_state = s; tdi = t; cap_data = cap;
        #1;
        o_tdo = tdo; o_en = tdo_en;
        chk("tdo", tdo, model_tdo(s));
        chk("tdo_en", tdo_en, (s == 4'h2) || (s == 4'hA));
        model_step(r, s, t, cap);
        @(posedge clock); #1;
        chk("instruction", instruction, m_instr);
        chk("update_valid", upd_valid, m_valid);
        chk("update_data", upd_data, m_data);
    endtask

    task automatic go(input logic [3:0] s);
        logic a, b;
        apply(1'b1, s, 1'($urandom), $urandom, a, b);
    endtask

    task automatic ir_scan(input logic [4:0] op);
        logic a, b;
        go(4'hC); go(4'h4); go(4'hE);
        for (int i = 0; i < 5; i++) begin
            if ($urandom_range(3) == 0) begin go(4'h9); go(4'hB); go(4'h8); end
            apply(1'b1, 4'hA, op[i], $urandom, a, b);
        end
        go(4'h9); go(4'hD); go(4'hC);
    endtask

    task automatic dr_scan(input int n);
        logic a, b;
        go(4'h7); go(4'h6);
        for (int i = 0; i < n; i++) begin
            apply(($urandom_range(40) != 0), 4'h2, 1'($urandom), $urandom, a, b);
            if ($urandom_range(7) == 0) begin go(4'h1); go(4'h3); go(4'h0); end
        end
        go(4'h1); go(4'h5); go(4'hC);
    endtask

    typedef struct {
        logic       rst_n;
        logic [3:0] st;
        logic       tdi;
        logic       exp_tdo;
        logic       exp_en;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] s, input logic t,
                                input logic e_tdo, input logic e_en);
        vec_t v;
        v.rst_n = r; v.st = s; v.tdi = t; v.exp_tdo = e_tdo; v.exp_en = e_en;
        vecs.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        a, b;
        logic [31:0] got;
        logic [31:0] wdata;
        logic [4:0]  capir;
        logic [4:0]  op;

        capir = ir_capture_value();
        reset = 1'b0; curr_state = 4'hF; tdi = 1'b0; cap_data = 0;
        m_ir = 0; m_instr = IDC; m_id = 0; m_user = 0; m_byp = 0; m_valid = 0; m_data = 0;
        @(posedge clock); #1;

        // IDCODE read after reset, then an IR load of USER_INST
        add(0, 4'hF, 0, 0, 0); add(1, 4'hF, 0, 0, 0); add(1, 4'hC, 0, 0, 0);
        add(1, 4'h7, 0, 0, 0); add(1, 4'h6, 0, 0, 0);
        for (int i = 0; i < 32; i++) add(1, 4'h2, 0, IDV[i], 1);
        add(1, 4'h1, 0, 0, 0); add(1, 4'h5, 0, 0, 0); add(1, 4'hC, 0, 0, 0);
        add(1, 4'h4, 0, 0, 0); add(1, 4'hE, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(1, 4'hA, USR[i], capir[i], 1);
        add(1, 4'h9, 0, 0, 0); add(1, 4'hD, 0, 0, 0); add(1, 4'hC, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst_n, vecs[i].st, vecs[i].tdi, 32'h0, a, b);
            chk("vec_tdo", a, vecs[i].exp_tdo);
            chk("vec_tdo_en", b, vecs[i].exp_en);
        end
        chk("ir_load_instr", instruction, USR);

        // User write: capture A5A5A5A5, shift in DEADBEEF
        wdata = 32'hDEADBEEF;
        go(4'h7);
        apply(1'b1, 4'h6, 1'b0, 32'hA5A5A5A5, a, b);
        for (int i = 0; i < 32; i++) begin
            apply(1'b1, 4'h2, wdata[i], 32'h0, a, b);
            got[i] = a;
        end
        chk("user_tdo_stream", got, 32'hA5A5A5A5);
        go(4'h1); go(4'h5);
        chk("user_strobe", upd_valid, 1'b1);
        chk("user_data", upd_data, 32'hDEADBEEF);
        go(4'hC);
        chk("user_strobe_width", upd_valid, 1'b0);

        // Bypass: one-cycle delay, no strobe
        ir_scan(5'h1F);
        go(4'h7); go(4'h6);
        got = 0;
        wdata = 32'b1011;
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 4'h2, wdata[i], 32'h0, a, b);
            got[i] = a;
        end
        chk("bypass_tdo", got, 32'b0110);
        go(4'h1); go(4'h5);
        chk("bypass_no_strobe", upd_valid, 1'b0);

        // TestLogicReset forces IDCODE but leaves update data alone
        ir_scan(USR);
        chk("user_inst_loaded", instruction, USR);
        go(4'hF);
        chk("tlr_instr", instruction, IDC);
        chk("tlr_data_held", upd_data, 32'hDEADBEEF);

        // Reset mid-shift aborts the scan
        ir_scan(USR);
        go(4'h7); go(4'h6);
        for (int i = 0; i < 10; i++) apply(1'b1, 4'h2, 1'($urandom), 32'h0, a, b);
        apply(1'b0, 4'h2, 1'b1, 32'h0, a, b);
        go(4'h1); go(4'h5);
        chk("abort_no_strobe", upd_valid, 1'b0);
        chk("abort_instr", instruction, IDC);
        chk("abort_data", upd_data, 32'h0);

        // Randomized scans against the model
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(3))
                0: op = IDC;
                1: op = USR;
                2: op = 5'h1F;
                default: op = 5'($urandom);
            endcase
            ir_scan(op);
            dr_scan($urandom_range(40));
            if ($urandom_range(5) == 0) go(4'hF);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
